// File: rtl/rvcpu_pkg.sv
// Shared types for the memory stage: execute/memory records, FSM states and
// load/store size decode.
package rvcpu;

    localparam int Width = 32;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

    typedef struct packed {
        logic [Width-1:0] data;
        logic [Width-1:0] addr;
        logic [4:0]       rd;
        logic             rd_valid;
        logic             is_mem;
        logic [3:0]       op;
    } stage_ex_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [Width-1:0] data;
        logic             misaligned;
    } stage_mem_t;

    // Unknown funct3 encodings fall back to a full word access.
    function automatic mem_size_t mem_size(input logic [2:0] funct3);
        case (funct3)
            MEM_B, MEM_BU: mem_size = SZ_B;
            MEM_H, MEM_HU: mem_size = SZ_H;
            MEM_W:         mem_size = SZ_W;
            default:       mem_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: store enables/data/alignment from the request side and
// load extraction/extension from the response side.
module mem_align
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic [1:0]       st_addr_lo,
    input  logic [2:0]       st_funct3,
    input  logic [Width-1:0] st_data,
    output logic [3:0]       st_be,
    output logic [Width-1:0] st_wdata,
    output logic             st_misaligned,
    input  logic [1:0]       ld_addr_lo,
    input  logic [2:0]       ld_funct3,
    input  logic [Width-1:0] ld_rdata,
    output logic [Width-1:0] ld_data
);

    logic [Width-1:0] ld_shifted;

    always_comb begin
        st_be         = 4'b1111;
        st_wdata      = st_data;
        st_misaligned = 1'b0;
        case (mem_size(st_funct3))
            SZ_B: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {(Width/8){st_data[7:0]}};
            end
            SZ_H: begin
                st_be         = 4'b0011 << st_addr_lo;
                st_wdata      = {(Width/16){st_data[15:0]}};
                st_misaligned = st_addr_lo[0];
            end
            default: st_misaligned = |st_addr_lo;
        endcase
    end

    assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        case (ld_funct3)
            MEM_B:   ld_data = {{(Width-8){ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_BU:  ld_data = {{(Width-8){1'b0}}, ld_shifted[7:0]};
            MEM_H:   ld_data = {{(Width-16){ld_shifted[15]}}, ld_shifted[15:0]};
            MEM_HU:  ld_data = {{(Width-16){1'b0}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory pipeline stage: registers ALU results and runs one req/ack data
// memory transaction per load/store, stalling upstream while it waits.
module stage_mem
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  stage_ex_t        ex,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [Width-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [Width-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [Width-1:0] dmem_rdata,
    output stage_mem_t       out
);

    mem_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [Width-1:0] addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_valid_q, rd_valid_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    stage_mem_t       out_q, out_d;

    logic [3:0]       st_be;
    logic [Width-1:0] st_wdata;
    logic             st_misaligned;
    logic [Width-1:0] ld_data;

    mem_align #(.Width(Width)) u_align (
        .st_addr_lo    (ex.addr[1:0]),
        .st_funct3     (ex.op[2:0]),
        .st_data       (ex.data),
        .st_be         (st_be),
        .st_wdata      (st_wdata),
        .st_misaligned (st_misaligned),
        .ld_addr_lo    (addr_lo_q),
        .ld_funct3     (funct3_q),
        .ld_rdata      (dmem_rdata),
        .ld_data       (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rd_valid_d = rd_valid_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        out_d      = out_q;
        out_d.valid = 1'b0;
        stall      = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (in_valid && !ex.is_mem) begin
                    out_d.valid      = 1'b1;
                    out_d.rd         = ex.rd;
                    out_d.rd_valid   = ex.rd_valid;
                    out_d.data       = ex.data;
                    out_d.misaligned = 1'b0;
                end else if (in_valid && st_misaligned) begin
                    // Faulting access retires immediately without touching memory.
                    out_d.valid      = 1'b1;
                    out_d.rd         = ex.rd;
                    out_d.rd_valid   = 1'b0;
                    out_d.data       = '0;
                    out_d.misaligned = 1'b1;
                end else if (in_valid) begin
                    stall      = 1'b1;
                    state_d    = MEM_WAIT;
                    req_d      = 1'b1;
                    we_d       = ex.op[3];
                    addr_d     = {ex.addr[Width-1:2], 2'b00};
                    be_d       = st_be;
                    wdata_d    = ex.op[3] ? st_wdata : '0;
                    rd_d       = ex.rd;
                    rd_valid_d = ex.rd_valid;
                    funct3_d   = ex.op[2:0];
                    addr_lo_d  = ex.addr[1:0];
                end
            end
            MEM_WAIT: begin
                // Stall drops in the ack cycle so upstream advances on the same edge.
                if (dmem_ack) begin
                    state_d          = MEM_IDLE;
                    req_d            = 1'b0;
                    out_d.valid      = 1'b1;
                    out_d.rd         = rd_q;
                    out_d.misaligned = 1'b0;
                    out_d.rd_valid   = we_q ? 1'b0 : rd_valid_q;
                    out_d.data       = we_q ? '0 : ld_data;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            out_q      <= out_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign out        = out_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: stimulus pushes expected retirements into a
// scoreboard queue that a negedge monitor drains whenever out.valid is seen.
module tb_stage_mem;
    import rvcpu::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    stage_ex_t   ex;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    stage_mem_t  out;

    typedef struct {
        stage_mem_t o;
        bit         chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    stage_mem #(.Width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ex         (ex),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .out        (out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic stage_ex_t mk_ex(input logic [31:0] data, input logic [31:0] addr,
                                        input logic [4:0] rd, input logic is_mem,
                                        input logic [3:0] op);
        stage_ex_t e;
        e.data     = data;
        e.addr     = addr;
        e.rd       = rd;
        e.rd_valid = 1'b1;
        e.is_mem   = is_mem;
        e.op       = op;
        return e;
    endfunction

    // Monitor: every retirement must match the oldest expected record.
    always @(negedge clk) begin
        if (out.valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: got rd=%0d data=0x%08h expected no retirement",
                         out.rd, out.data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_misaligned", 32'(out.misaligned), 32'(e.o.misaligned));
                check("out_rd_valid", 32'(out.rd_valid), 32'(e.o.rd_valid));
                if (e.o.rd_valid) check("out_rd", 32'(out.rd), 32'(e.o.rd));
                if (e.chk_data) check("out_data", out.data, e.o.data);
                $display("retire rd=%0d rd_valid=%0b data=0x%08h misaligned=%0b",
                         out.rd, out.rd_valid, out.data, out.misaligned);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic rd_valid, input logic [31:0] data,
                            input logic mis, input bit chk_data);
        exp_t x;
        x.o            = '0;
        x.o.valid      = 1'b1;
        x.o.rd         = rd;
        x.o.rd_valid   = rd_valid;
        x.o.data       = data;
        x.o.misaligned = mis;
        x.chk_data     = chk_data;
        sb.push_back(x);
    endtask

    // Called at posedge+1; returns at posedge+1 with the record consumed.
    task automatic do_alu(input stage_ex_t e);
        in_valid = 1'b1;
        ex       = e;
        push_exp(e.rd, 1'b1, e.data, 1'b0, 1'b1);
        #1 check("alu_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("alu_no_req", 32'(dmem_req), 32'd0);
    endtask

    task automatic do_mis(input stage_ex_t e);
        in_valid = 1'b1;
        ex       = e;
        push_exp(e.rd, 1'b0, 32'd0, 1'b1, 1'b0);
        #1 check("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mis_no_req", 32'(dmem_req), 32'd0);
    endtask

    task automatic do_mem(input string tag, input stage_ex_t e, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data);
        logic st;
        int   stall_cycles;
        st = e.op[3];
        stall_cycles = 0;
        in_valid = 1'b1;
        ex       = e;
        #1 check({tag, "_stall_idle"}, 32'(stall), 32'd1);
        stall_cycles += int'(stall);
        @(posedge clk); #1;
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'(st));
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        if (st) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            #1 stall_cycles += int'(stall);
            @(posedge clk); #1;
            check({tag, "_req_held"}, 32'(dmem_req), 32'd1);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        push_exp(e.rd, ~st, st ? 32'd0 : exp_data, 1'b0, 1'b1);
        #1 check({tag, "_stall_ack"}, 32'(stall), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(waits + 1));
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        ex         = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_alu(mk_ex(32'h0000_1234, 32'h0, 5'd5, 1'b0, 4'h0));
        do_alu(mk_ex(32'hDEAD_BEEF, 32'h0, 5'd31, 1'b0, 4'h0));
        // LB from byte 3: 0x80 sign-extends.
        do_mem("lb", mk_ex(32'h0, 32'h0000_1003, 5'd7, 1'b1, 4'b0000), 3,
               32'h80FF_FF00, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_mem("lhu", mk_ex(32'h0, 32'h0000_2002, 5'd8, 1'b1, 4'b0101), 1,
               32'hBEEF_0000, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_BEEF);
        do_mem("lw", mk_ex(32'h0, 32'h0000_2004, 5'd9, 1'b1, 4'b0010), 0,
               32'h8765_4321, 32'h0000_2004, 4'b1111, 32'h0, 32'h8765_4321);
        do_mem("sb", mk_ex(32'h0000_00AB, 32'h0000_3001, 5'd10, 1'b1, 4'b1000), 2,
               32'h0, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB, 32'h0);
        do_mem("sh", mk_ex(32'h1234_CDEF, 32'h0000_3002, 5'd11, 1'b1, 4'b1001), 1,
               32'h0, 32'h0000_3000, 4'b1100, 32'hCDEF_CDEF, 32'h0);
        do_mis(mk_ex(32'h0, 32'h0000_4002, 5'd12, 1'b1, 4'b0010));
        do_mis(mk_ex(32'h0, 32'h0000_4001, 5'd13, 1'b1, 4'b1001));

        // Reset during WAIT, then a stale ack must not retire anything.
        in_valid = 1'b1;
        ex       = mk_ex(32'h0, 32'h0000_5000, 5'd14, 1'b1, 4'b0010);
        @(posedge clk); #1;
        check("rstw_req", 32'(dmem_req), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstw_req_drop", 32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("late_ack_no_valid", 32'(out.valid), 32'd0);
        check("late_ack_no_req", 32'(dmem_req), 32'd0);

        repeat (3) @(posedge clk);
        #1 check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
